// File: rtl/spi_flash_pkg.sv
// -----------------------------------------------------------------------------
// spi_flash_pkg
// Shared definitions for the serial NOR flash command side. The responder
// and the master-side ctrl modules both use these values.
//   - opcode constants (WREN, WRDI, RDSR, RDID, BE)
//   - responder state enum
//   - status register bit positions
//   - is_write_op(): opcodes that only take effect when the frame closes
// -----------------------------------------------------------------------------
package spi_flash_pkg;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_BE   = 8'hC7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMD    = 2'd1,
        ST_DOUT   = 2'd2,
        ST_IGNORE = 2'd3
    } flash_state_e;

    localparam int STATUS_WIP = 0;
    localparam int STATUS_WEL = 1;

    // Write-type opcodes are held pending until chip select rises.
    function automatic logic is_write_op(input logic [7:0] op);
        return (op == OP_WREN) || (op == OP_WRDI) || (op == OP_BE);
    endfunction

endpackage

// File: rtl/spi_flash_responder_if.sv
// -----------------------------------------------------------------------------
// spi_flash_responder_if
// The four SPI wires between a flash command master and the responder.
//   spi_sclk  master -> slave  serial clock, mode 0 (idles low)
//   spi_cs    master -> slave  chip select, active-low
//   spi_mosi  master -> slave  serial data, MSB first
//   spi_miso  slave -> master  serial data, 0 while deselected
//
// Handshake: none beyond SPI mode 0. The master changes mosi while sclk is
// low and the slave samples it on the sclk rise. The slave changes miso after
// the sclk fall and the master samples it on the next rise. A frame is the
// interval with spi_cs low.
// -----------------------------------------------------------------------------
interface spi_flash_responder_if;
    logic spi_sclk;
    logic spi_cs;
    logic spi_mosi;
    logic spi_miso;

    modport master (
        output spi_sclk,
        output spi_cs,
        output spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  spi_sclk,
        input  spi_cs,
        input  spi_mosi,
        output spi_miso
    );
endinterface

// File: rtl/spi_slave_phy.sv
// -----------------------------------------------------------------------------
// spi_slave_phy
// Bit-level SPI mode-0 slave. It moves the asynchronous SPI wires into the
// clk domain and presents a byte-level interface to the command decoder.
//   clk, rst    system clock, synchronous active-high reset
//   spi         slave modport of the SPI bus
//   sclk_rise   one-cycle pulse per sclk rise inside a frame
//   sclk_fall   one-cycle pulse per sclk fall inside a frame
//   cs_rise     one-cycle pulse when the frame ends
//   cs_fall     one-cycle pulse when the frame starts
//   rx_valid    one-cycle pulse after every 8th received bit of a frame
//   rx_byte     byte completed by the last rx_valid
//   tx_load     load tx_data into the transmit shift register
//   tx_data     24-bit transmit word, MSB goes out first
//
// Each input passes two synchronizer flops. A third flop holds the previous
// synchronized value for edge detection. This gives 3 clk cycles from a pin
// change to the registered effect of that change. sclk edges count only
// while the synchronized cs is low. On the cycle cs_rise fires, the
// synchronized cs is already high, so an sclk edge in that cycle is dropped.
// -----------------------------------------------------------------------------
module spi_slave_phy (
    input  logic                        clk,
    input  logic                        rst,
    spi_flash_responder_if.slave        spi,
    output logic                        sclk_rise,
    output logic                        sclk_fall,
    output logic                        cs_rise,
    output logic                        cs_fall,
    output logic                        rx_valid,
    output logic [7:0]                  rx_byte,
    input  logic                        tx_load,
    input  logic [23:0]                 tx_data
);

    logic        sclk_s1, sclk_s2, sclk_d;
    logic        cs_s1, cs_s2, cs_d;
    logic        mosi_s1, mosi_s2;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_sr;
    logic [23:0] tx_sr;
    logic        miso_q;

    assign sclk_rise = sclk_s2 & ~sclk_d & ~cs_s2;
    assign sclk_fall = ~sclk_s2 & sclk_d & ~cs_s2;
    assign cs_rise   = cs_s2 & ~cs_d;
    assign cs_fall   = ~cs_s2 & cs_d;

    assign spi.spi_miso = miso_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1  <= 1'b0;
            sclk_s2  <= 1'b0;
            sclk_d   <= 1'b0;
            cs_s1    <= 1'b1;
            cs_s2    <= 1'b1;
            cs_d     <= 1'b1;
            mosi_s1  <= 1'b0;
            mosi_s2  <= 1'b0;
            bit_cnt  <= 3'd0;
            rx_sr    <= 7'd0;
            rx_valid <= 1'b0;
            rx_byte  <= 8'd0;
            tx_sr    <= 24'd0;
            miso_q   <= 1'b0;
        end else begin
            sclk_s1  <= spi.spi_sclk;
            sclk_s2  <= sclk_s1;
            sclk_d   <= sclk_s2;
            cs_s1    <= spi.spi_cs;
            cs_s2    <= cs_s1;
            cs_d     <= cs_s2;
            mosi_s1  <= spi.spi_mosi;
            mosi_s2  <= mosi_s1;
            rx_valid <= 1'b0;

            if (cs_fall || cs_rise) begin
                // A new frame starts from a clean slate, so leftover data
                // from a cut-short read cannot leak out.
                bit_cnt <= 3'd0;
                tx_sr   <= 24'd0;
                miso_q  <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    rx_sr   <= {rx_sr[5:0], mosi_s2};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_valid <= 1'b1;
                        rx_byte  <= {rx_sr, mosi_s2};
                    end
                end

                if (sclk_fall) begin
                    miso_q <= tx_sr[23];
                end

                if (tx_load) begin
                    tx_sr <= tx_data;
                end else if (sclk_fall) begin
                    tx_sr <= {tx_sr[22:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/spi_flash_responder.sv
// -----------------------------------------------------------------------------
// spi_flash_responder
// Synthesizable stand-in for the command side of a serial NOR flash. It
// decodes WREN, WRDI, RDSR, RDID and BE, keeps the WEL/WIP status bits, and
// runs a timed bulk-erase busy window.
//   sys_clk, sys_rst  system clock, synchronous active-high reset
//   spi               slave modport of the SPI bus
//   erase_start       one-cycle pulse when a bulk erase is accepted
//   erase_busy        WIP status bit
//   cmd_valid         one-cycle pulse when the command byte of a frame arrives
//   cmd_byte          that command byte
//   dbg_state         current decoder state (IDLE/CMD/DOUT/IGNORE encoding)
//
// Parameters
//   ERASE_CYCLES  sys_clk cycles WIP stays high after an accepted BE (>= 1)
//   JEDEC_ID      RDID response, MSB byte first
// -----------------------------------------------------------------------------
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          ERASE_CYCLES = 1000,
    parameter logic [23:0] JEDEC_ID     = 24'h202017
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    spi_flash_responder_if.slave    spi,
    output logic                    erase_start,
    output logic                    erase_busy,
    output logic                    cmd_valid,
    output logic [7:0]              cmd_byte,
    output logic [1:0]              dbg_state
);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_CMD    = ST_CMD;
    localparam logic [1:0] S_DOUT   = ST_DOUT;
    localparam logic [1:0] S_IGNORE = ST_IGNORE;

    localparam int BCW = (ERASE_CYCLES > 1) ? $clog2(ERASE_CYCLES) : 1;

    logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        tx_load;
    logic [23:0] tx_data;

    logic [1:0]  state;
    logic        pend_valid;
    logic [7:0]  pend_cmd;
    logic        dout_rdsr;
    logic [2:0]  dout_cnt;
    logic        reload_q;
    logic        commit;

    logic        wel, wip;
    logic [BCW-1:0] busy_cnt;
    logic [7:0]  status;

    spi_slave_phy u_phy (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .spi       (spi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_rise   (cs_rise),
        .cs_fall   (cs_fall),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .tx_load   (tx_load),
        .tx_data   (tx_data)
    );

    always_comb begin
        status = 8'h00;
        status[STATUS_WEL] = wel;
        status[STATUS_WIP] = wip;
    end

    // Only the first byte of a frame is a command. A frame that already
    // holds a pending write command never produces a second cmd_valid.
    assign cmd_valid = rx_valid && (state == S_CMD) && !pend_valid;
    assign cmd_byte  = rx_byte;

    // The first load happens in the cycle after the 8th rise is recognised.
    // The 8th fall is at least four sys_clk cycles later, so the MSB is in
    // place for that fall. RDSR reloads in the cycle after each 8th data fall.
    assign tx_load = (cmd_valid && ((rx_byte == OP_RDSR) || (rx_byte == OP_RDID)))
                   || reload_q;
    assign tx_data = (cmd_valid && (rx_byte == OP_RDID)) ? JEDEC_ID
                                                         : {status, 16'h0000};

    // A pending write command executes only if the frame closes right after
    // exactly 8 bits. A 9th rise moves to IGNORE and clears pend_valid.
    assign commit = cs_rise && (state == S_CMD) && pend_valid;

    assign erase_busy = wip;
    assign dbg_state  = state;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= S_IDLE;
            pend_valid <= 1'b0;
            pend_cmd   <= 8'h00;
            dout_rdsr  <= 1'b0;
            dout_cnt   <= 3'd0;
            reload_q   <= 1'b0;
        end else begin
            reload_q <= 1'b0;
            if (cs_rise) begin
                state      <= S_IDLE;
                pend_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cs_fall) begin
                            state      <= S_CMD;
                            pend_valid <= 1'b0;
                        end
                    end
                    S_CMD: begin
                        if (cmd_valid) begin
                            dout_cnt <= 3'd0;
                            if (rx_byte == OP_RDSR) begin
                                state     <= S_DOUT;
                                dout_rdsr <= 1'b1;
                            end else if (rx_byte == OP_RDID) begin
                                state     <= S_DOUT;
                                dout_rdsr <= 1'b0;
                            end else if (is_write_op(rx_byte)) begin
                                pend_valid <= 1'b1;
                                pend_cmd   <= rx_byte;
                            end else begin
                                state <= S_IGNORE;
                            end
                        end else if (sclk_rise && pend_valid) begin
                            state      <= S_IGNORE;
                            pend_valid <= 1'b0;
                        end
                    end
                    S_DOUT: begin
                        if (sclk_fall) begin
                            dout_cnt <= dout_cnt + 3'd1;
                            if (dout_rdsr && (dout_cnt == 3'd7)) begin
                                reload_q <= 1'b1;
                            end
                        end
                    end
                    S_IGNORE: begin
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Status and the erase timer. erase_start and the counter load happen on
    // the accept edge, and WIP follows one cycle later. The counter counts
    // ERASE_CYCLES-1 down to 0 while WIP is high. WIP therefore stays high
    // for exactly ERASE_CYCLES cycles, and WEL clears on the same edge.
    // Commands are evaluated against the current WIP. A BE on the final busy
    // cycle is therefore rejected.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wel         <= 1'b0;
            wip         <= 1'b0;
            busy_cnt    <= '0;
            erase_start <= 1'b0;
        end else begin
            erase_start <= 1'b0;

            if (erase_start) begin
                wip <= 1'b1;
            end else if (wip) begin
                if (busy_cnt == '0) begin
                    wip <= 1'b0;
                    wel <= 1'b0;
                end else begin
                    busy_cnt <= busy_cnt - BCW'(1);
                end
            end

            if (commit && !wip) begin
                case (pend_cmd)
                    OP_WREN: wel <= 1'b1;
                    OP_WRDI: wel <= 1'b0;
                    OP_BE: begin
                        if (wel) begin
                            erase_start <= 1'b1;
                            busy_cnt    <= BCW'(ERASE_CYCLES - 1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

SPI mode-0 slave that models the command side of a serial NOR flash: it is the far end of our SPI flash command masters. It decodes WREN, WRDI, RDSR, RDID and BE (bulk erase) from the SPI bus, maintains the WEL/WIP status bits and runs a timed bulk-erase busy window. It serves as a synthesizable flash stand-in for the SPI command masters on board and in simulation, and exposes erase events to the fabric.

## Interface
- ERASE_CYCLES, 1000: sys_clk cycles WIP stays high after an accepted BE (minimum 1)
- JEDEC_ID, 24'h202017: RDID response bytes, MSB byte first
- sys_clk  in  1  system clock, 50 MHz
- sys_rst  in  1  synchronous reset, active-high
- spi_sclk  in  1  SPI clock from master; frequency must not exceed sys_clk/8
- spi_cs  in  1  chip select, active-low
- spi_mosi  in  1  serial data from master
- spi_miso  out  1  serial data to master; 0 while deselected
- erase_start  out  1  one-cycle pulse when a bulk erase is accepted
- erase_busy  out  1  equals WIP
- cmd_valid  out  1  one-cycle pulse when 8 command bits have been received
- cmd_byte  out  8  last received command byte, valid with cmd_valid

## Operation
- Synchronization: sclk, cs and mosi each pass through 2-FF synchronizers; rise/fall detection on synchronized sclk; cs_rise/cs_fall detection on synchronized cs.
- Protocol: mode 0, MSB first. mosi is sampled on sclk rise; miso changes on sclk fall.
- State machine states are IDLE, CMD, DOUT and IGNORE.
  - IDLE → CMD on cs_fall. Bit counter is cleared.
  - CMD: shifts mosi on each rise. The 8th rise pulses cmd_valid and decodes the byte:
    - 0x05 (RDSR) → DOUT, loading status {6'b0, WEL, WIP}.
    - 0x9F (RDID) → DOUT, loading JEDEC_ID.
    - 0x06, 0x04 or 0xC7 → remain in CMD as a pending command; any further rise moves to IGNORE and the pending command is dropped.
    - Any other byte → IGNORE.
  - DOUT: the shift register drives miso, with the MSB placed on the first fall after the 8th command rise. RDSR reloads the live status every 8 bits, indefinitely. RDID shifts 24 bits, then outputs 0.
  - IGNORE: no action until cs_rise.
  - Any state → IDLE on cs_rise. Only there do pending commands execute, and only if exactly 8 bits were received:
    - WREN sets WEL.
    - WRDI clears WEL.
    - BE is accepted if WEL=1 and WIP=0: pulse erase_start, set WIP, load the busy counter with ERASE_CYCLES-1.
- Busy behaviour:
  - While WIP=1, WREN, WRDI and BE are ignored. RDSR and RDID work.
  - The counter decrements each cycle. At 0, WIP and WEL are cleared on the same edge.
  - A BE with WEL=0 is ignored silently.
- A cs_rise mid-byte (1–7 bits) aborts the command with no state change.
- Reset values: state IDLE, WEL=0, WIP=0, counter 0, all outputs 0, synchronizers 0 except cs, which resets to 1.

## Timing
- Input-to-internal latency is 3 sys_clk cycles: 2 synchronizer stages plus the edge register.
- cmd_valid asserts 3 cycles after the 8th physical sclk rise.
- erase_start asserts 3 cycles after the physical cs rise. WIP rises the next cycle and stays high for exactly ERASE_CYCLES cycles.
- miso updates 3 cycles after the physical sclk fall. At sclk ≤ sys_clk/8 the data settles before the master's next rise.
- cs_rise and an sclk edge in the same cycle: cs_rise wins and the edge is discarded.
- Busy counter reaching 0 in the same cycle as a BE commit: the BE is rejected, since WIP was still 1 at evaluation.
- Reset asserted mid-erase clears WIP immediately. No erase_start is regenerated.

## Structure
- Shared package spi_flash_pkg holds:
  - Opcode constants: OP_WREN 8'h06, OP_WRDI 8'h04, OP_RDSR 8'h05, OP_RDID 8'h9F, OP_BE 8'hC7.
  - The state enum.
  - Status bit indices: WIP=0, WEL=1.
  - The same opcodes are used by the master-side ctrl modules.
- One natural sub-module is spi_slave_phy. It contains the synchronizers, edge detection, bit counter, rx shift register and tx shift register, and presents byte-level rx_valid/rx_byte and a tx_load interface. Decode, status and busy timer stay in the top level.

## Test plan
- WREN (cs frame), then BE frame → erase_start pulses once; erase_busy is high for exactly ERASE_CYCLES (1000) cycles; a following RDSR returns 8'h00.
- BE without a prior WREN → no erase_start; RDSR returns 8'h00.
- WREN, BE, then RDSR held for 3 bytes during the erase → miso bytes are 8'h03, 8'h03, 8'h03; after the busy window, RDSR returns 8'h00.
- RDID frame of 32 clocks → 8'h20, 8'h20, 8'h17, then 8'h00.
- WREN aborted after 5 bits by a cs rise, then RDSR → 8'h00. Separately, WREN with 9 bits followed by RDSR → 8'h00.
- Reset pulse 100 cycles into an erase → erase_busy goes 0 the next cycle; RDSR returns 8'h00; no second erase_start.
